// File: rtl/dm_read_cache.sv
// Direct-mapped, read-only cache with a single-beat line refill from memory.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count statistics ports.
module dm_read_cache #(
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned INDEX_WIDTH  = 10,
  parameter int unsigned OFFSET_WIDTH = 2,
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned STAT_WIDTH   = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cpu_req,
  input  logic [ADDR_WIDTH-1:0]                   cpu_addr,
  input  logic                                    flush,
  output logic                                    cpu_ready,
  output logic                                    cpu_hit,
  output logic [WORD_WIDTH-1:0]                   cpu_data,
  output logic                                    cpu_stall,
  output logic                                    mem_read,
  output logic [ADDR_WIDTH-1:0]                   mem_addr,
  input  logic                                    mem_valid,
  input  logic [(WORD_WIDTH<<OFFSET_WIDTH)-1:0]   mem_data
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]                   hit_count,
  output logic [STAT_WIDTH-1:0]                   miss_count
`endif
);

  localparam int unsigned TagWidth  = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned Lines     = 1 << INDEX_WIDTH;
  localparam int unsigned Words     = 1 << OFFSET_WIDTH;
  localparam int unsigned LineWidth = WORD_WIDTH << OFFSET_WIDTH;

  typedef enum logic [0:0] {StIdle, StRefill} state_e;

  state_e state_q, state_d;

  logic [Lines-1:0]         valid_q;
  logic [TagWidth-1:0]      line_tag_q  [Lines];
  logic [LineWidth-1:0]     line_data_q [Lines];

  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     ready_q;
  logic                     hit_q;
  logic [WORD_WIDTH-1:0]    rsp_data_q;

  logic [INDEX_WIDTH-1:0]   req_index;
  logic [TagWidth-1:0]      req_tag;
  logic [OFFSET_WIDTH-1:0]  req_offset;
  logic [INDEX_WIDTH-1:0]   fill_index;
  logic [TagWidth-1:0]      fill_tag;
  logic [OFFSET_WIDTH-1:0]  fill_offset;
  logic [LineWidth-1:0]     req_line;
  logic                     lookup_hit;
  logic [WORD_WIDTH-1:0]    hit_word;
  logic [WORD_WIDTH-1:0]    fill_word;
  logic                     accept;
  logic                     refill_done;

  assign req_index   = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_tag     = cpu_addr[ADDR_WIDTH-1 -: TagWidth];
  assign req_offset  = cpu_addr[OFFSET_WIDTH-1:0];
  assign fill_index  = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign fill_tag    = addr_q[ADDR_WIDTH-1 -: TagWidth];
  assign fill_offset = addr_q[OFFSET_WIDTH-1:0];

  assign req_line    = line_data_q[req_index];
  assign lookup_hit  = valid_q[req_index] && (line_tag_q[req_index] == req_tag);
  assign accept      = (state_q == StIdle) && cpu_req;
  assign refill_done = (state_q == StRefill) && mem_valid;

  always_comb begin
    hit_word  = '0;
    fill_word = '0;
    for (int unsigned w = 0; w < Words; w++) begin
      if (req_offset == w[OFFSET_WIDTH-1:0]) hit_word = req_line[w*WORD_WIDTH +: WORD_WIDTH];
      if (fill_offset == w[OFFSET_WIDTH-1:0]) fill_word = mem_data[w*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cpu_req && !lookup_hit) state_d = StRefill;
      StRefill: if (mem_valid) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign mem_read  = (state_q == StRefill);
  assign cpu_stall = (state_q == StRefill);
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  assign cpu_ready = ready_q;
  assign cpu_hit   = hit_q;
  assign cpu_data  = rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b0;
      hit_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b0;
      if (accept) begin
        if (lookup_hit) begin
          ready_q    <= 1'b1;
          hit_q      <= 1'b1;
          rsp_data_q <= hit_word;
        end else begin
          addr_q <= cpu_addr;
        end
      end
      if (refill_done) begin
        ready_q    <= 1'b1;
        hit_q      <= 1'b0;
        rsp_data_q <= fill_word;
      end
      // A flush on the refill-completion edge leaves the new line invalid.
      if (flush) begin
        valid_q <= '0;
      end else if (refill_done) begin
        valid_q[fill_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && refill_done) begin
      line_tag_q[fill_index]  <= fill_tag;
      line_data_q[fill_index] <= mem_data;
    end
  end

`ifdef CACHE_STATS_EN
  logic [STAT_WIDTH-1:0] hit_cnt_q;
  logic [STAT_WIDTH-1:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (lookup_hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_read_cache.sv
// Directed self-checking bench for dm_read_cache; statistics checks run when
// CACHE_STATS_EN is defined.
module tb_dm_read_cache;

  localparam int unsigned AW = 15;
  localparam int unsigned WW = 32;
  localparam int unsigned LW = WW * 4;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst, cpu_req, flush, mem_valid;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ready, cpu_hit, cpu_stall, mem_read;
  logic [WW-1:0] cpu_data;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_data;
`ifdef CACHE_STATS_EN
  logic [SW-1:0] hit_count, miss_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  dm_read_cache #(.STAT_WIDTH(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .flush     (flush),
    .cpu_ready (cpu_ready),
    .cpu_hit   (cpu_hit),
    .cpu_data  (cpu_data),
    .cpu_stall (cpu_stall),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_data  (mem_data)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [AW-1:0] a);
    cpu_req  = 1'b1;
    cpu_addr = a;
    step();
    cpu_req  = 1'b0;
  endtask

  task automatic refill(input logic [WW-1:0] w3, w2, w1, w0, input logic with_flush);
    mem_valid = 1'b1;
    mem_data  = {w3, w2, w1, w0};
    flush     = with_flush;
    step();
    mem_valid = 1'b0;
    flush     = 1'b0;
  endtask

  int stall_cycles;
  int read_cycles;
  int spurious_ready;

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0; mem_valid = 1'b0; mem_data = '0;
    step(); step();
    rst = 1'b0;
    check_eq("rst_ready", cpu_ready, 0);
    check_eq("rst_hit", cpu_hit, 0);
    check_eq("rst_data", cpu_data, 0);
    check_eq("rst_mem_read", mem_read, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_stall", cpu_stall, 0);

    // Cold miss on 0x0005 then refill
    request(15'h0005);
    check_eq("miss_ready", cpu_ready, 0);
    check_eq("miss_mem_read", mem_read, 1);
    check_eq("miss_mem_addr", mem_addr, 15'h0004);
    check_eq("miss_stall", cpu_stall, 1);
    refill(32'hD3, 32'hD2, 32'hD1, 32'hD0, 1'b0);
    check_eq("fill_ready", cpu_ready, 1);
    check_eq("fill_hit", cpu_hit, 0);
    check_eq("fill_data", cpu_data, 32'hD1);
    check_eq("fill_mem_read", mem_read, 0);
    step();
    check_eq("ready_pulse", cpu_ready, 0);
    check_eq("data_hold", cpu_data, 32'hD1);

    request(15'h0006);
    check_eq("hit_ready", cpu_ready, 1);
    check_eq("hit_hit", cpu_hit, 1);
    check_eq("hit_data", cpu_data, 32'hD2);
    check_eq("hit_mem_read", mem_read, 0);

    // Back-to-back hits
    cpu_req = 1'b1; cpu_addr = 15'h0004;
    step();
    check_eq("b2b0_data", cpu_data, 32'hD0);
    check_eq("b2b0_hit", cpu_hit, 1);
    cpu_addr = 15'h0007;
    step();
    cpu_req = 1'b0;
    check_eq("b2b1_ready", cpu_ready, 1);
    check_eq("b2b1_data", cpu_data, 32'hD3);

    // Conflict eviction: same index, tag 1
    request(15'h1004);
    check_eq("evict_mem_read", mem_read, 1);
    check_eq("evict_mem_addr", mem_addr, 15'h1004);
    refill(32'hE3, 32'hE2, 32'hE1, 32'hE0, 1'b0);
    check_eq("evict_data", cpu_data, 32'hE0);
    check_eq("evict_hit", cpu_hit, 0);
    request(15'h0004);
    check_eq("evicted_miss", mem_read, 1);
    check_eq("evicted_addr", mem_addr, 15'h0004);
    refill(32'hD3, 32'hD2, 32'hD1, 32'hD0, 1'b0);
    check_eq("refetch_data", cpu_data, 32'hD0);

    // Delayed mem_valid: five stall cycles, requests ignored meanwhile
    request(15'h0008);
    stall_cycles = 0; read_cycles = 0; spurious_ready = 0;
    for (int k = 0; k < 20; k++) begin
      if (!mem_read && !cpu_stall) break;
      if (mem_read) read_cycles++;
      if (cpu_stall) stall_cycles++;
      if (cpu_ready) spurious_ready++;
      mem_valid = (read_cycles == 5);
      mem_data  = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
      cpu_req   = (k % 2 == 0);
      cpu_addr  = 15'h0004;
      step();
    end
    cpu_req = 1'b0; mem_valid = 1'b0;
    check_eq("delay_read_cycles", read_cycles, 5);
    check_eq("delay_stall_cycles", stall_cycles, 5);
    check_eq("delay_no_ready", spurious_ready, 0);
    check_eq("delay_ready", cpu_ready, 1);
    check_eq("delay_data", cpu_data, 32'hF0);

    // Flush then miss; flush coincident with refill completion
    flush = 1'b1;
    step();
    flush = 1'b0;
    request(15'h0006);
    check_eq("flush_miss", mem_read, 1);
    refill(32'hD3, 32'hD2, 32'hD1, 32'hD0, 1'b1);
    check_eq("flushfill_ready", cpu_ready, 1);
    check_eq("flushfill_data", cpu_data, 32'hD2);
    request(15'h0006);
    check_eq("flushfill_remiss", mem_read, 1);
    refill(32'hD3, 32'hD2, 32'hD1, 32'hD0, 1'b0);
    request(15'h0005);
    check_eq("postflush_hit", cpu_hit, 1);
    check_eq("postflush_data", cpu_data, 32'hD1);

    // Reset during refill
    request(15'h1008);
    check_eq("prerst_mem_read", mem_read, 1);
    rst = 1'b1; flush = 1'b1; mem_valid = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; mem_valid = 1'b0;
    check_eq("midrst_mem_read", mem_read, 0);
    check_eq("midrst_stall", cpu_stall, 0);
    check_eq("midrst_ready", cpu_ready, 0);
    check_eq("midrst_data", cpu_data, 0);
    check_eq("midrst_mem_addr", mem_addr, 0);
    request(15'h0005);
    check_eq("midrst_line_lost", mem_read, 1);
    refill(32'hD3, 32'hD2, 32'hD1, 32'hD0, 1'b0);
    check_eq("midrst_fill_data", cpu_data, 32'hD1);

`ifdef CACHE_STATS_EN
    request(15'h0004);
    request(15'h0005);
    request(15'h0006);
    request(15'h1004);
    refill(32'hE3, 32'hE2, 32'hE1, 32'hE0, 1'b0);
    check_eq("stat_hits", hit_count, 3);
    check_eq("stat_misses", miss_count, 2);
    for (int i = 0; i < 20; i++) request(15'h1004);
    check_eq("stat_hits_sat", hit_count, 15);
    check_eq("stat_misses_hold", miss_count, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_read_cache.md
DM_READ_CACHE -- requirements
Module: dm_read_cache

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, word-address width.
REQ-002 SHALL have parameter INDEX_WIDTH, default 10, line-index width (2^INDEX_WIDTH lines).
REQ-003 SHALL have parameter OFFSET_WIDTH, default 2, word-in-line width (2^OFFSET_WIDTH words/line).
REQ-004 SHALL have parameter WORD_WIDTH, default 32, data word width.
REQ-005 SHALL have parameter STAT_WIDTH, default 16, statistics counter width.
REQ-006 SHALL have clk, input, 1: single clock, all state updates on its rising edge.
REQ-007 SHALL have rst, input, 1: synchronous active-high reset.
REQ-008 SHALL have cpu_req, input, 1: read request pulse; cpu_addr, input, ADDR_WIDTH: word address.
REQ-009 SHALL have flush, input, 1: invalidate all lines.
REQ-010 SHALL have cpu_ready, output, 1: response valid; cpu_hit, output, 1: response was a hit; cpu_data, output, WORD_WIDTH: response word.
REQ-011 SHALL have cpu_stall, output, 1: high while refilling; requests ignored.
REQ-012 SHALL have mem_read, output, 1; mem_addr, output, ADDR_WIDTH (offset bits zero); mem_valid, input, 1; mem_data, input, WORD_WIDTH*2^OFFSET_WIDTH (word 0 in LSBs).
REQ-013 SHALL have hit_count and miss_count, outputs, STAT_WIDTH each (present only with CACHE_STATS_EN).

Function
REQ-014 SHALL split cpu_addr as offset = [OFFSET_WIDTH-1:0], index = next INDEX_WIDTH bits, tag = remaining upper bits; each line stores valid, tag, data.
REQ-015 SHALL implement FSM states IDLE and REFILL; reset state IDLE.
REQ-016 Hit = line[index].valid AND stored tag equals tag.
REQ-017 IDLE, cpu_req=1, hit: next cycle cpu_ready=1, cpu_hit=1, cpu_data=selected word; stay IDLE; back-to-back requests accepted every cycle.
REQ-018 IDLE, cpu_req=1, miss: latch address, go REFILL next cycle; cpu_ready=0.
REQ-019 REFILL: mem_read=1, mem_addr={latched tag, latched index, zero offset}, cpu_stall=1, held until mem_valid sampled high.
REQ-020 REFILL with mem_valid=1: write line (valid=1, tag, mem_data), next cycle cpu_ready=1, cpu_hit=0, cpu_data=latched-offset word of mem_data, mem_read=0, state IDLE.
REQ-021 cpu_ready SHALL be a one-cycle pulse; cpu_data holds last response until the next one.
REQ-022 cpu_req while in REFILL SHALL be ignored (no response, no counter change).
REQ-023 mem_valid outside REFILL SHALL be ignored.
REQ-024 flush=1 SHALL clear all valid bits at the clock edge; any lookup in that same cycle uses pre-flush state.
REQ-025 flush coincident with refill completion: flush wins, refilled line left invalid; data still returned to CPU.
REQ-026 flush during REFILL does not abort the refill.

Reset
REQ-027 rst=1 SHALL force IDLE, clear all valid bits, cpu_ready=0, cpu_hit=0, cpu_data=0, mem_read=0, mem_addr=0, cpu_stall=0, counters=0, within one cycle, including mid-refill (pending request dropped).
REQ-028 rst SHALL take priority over flush, cpu_req and mem_valid.

Configuration
REQ-029 With CACHE_STATS_EN defined: hit_count increments per accepted hit, miss_count per accepted miss, each saturating at 2^STAT_WIDTH-1.
REQ-030 Without CACHE_STATS_EN: hit_count/miss_count ports and counter logic absent; all other behaviour identical.

Verification (defaults unless stated)
REQ-031 Reset; req 0x0005 -> miss, mem_read=1, mem_addr=0x0004; mem_valid with words {0xD3,0xD2,0xD1,0xD0} -> cpu_ready, cpu_hit=0, cpu_data=0xD1; then req 0x0006 -> next cycle cpu_hit=1, cpu_data=0xD2, no mem_read.
REQ-032 After REQ-031 fill, req 0x1004 (same index, tag 1) -> miss, refill; then req 0x0004 -> miss again (evicted).
REQ-033 Miss with mem_valid delayed 5 cycles -> mem_read and cpu_stall high exactly 5 cycles; cpu_req pulses meanwhile produce no cpu_ready.
REQ-034 Fill line 0x0004, pulse flush, req 0x0006 -> miss; flush on same cycle as mem_valid -> data returned, follow-up same-line req misses.
REQ-035 rst asserted during REFILL -> next cycle mem_read=0, state IDLE, prior-filled lines miss.
REQ-036 CACHE_STATS_EN, STAT_WIDTH=4: 3 hits, 2 misses -> hit_count=3, miss_count=2; 20 further hits -> hit_count=15.
